// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA pixel-write arbiter.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int COORD_W  = 8;
  localparam int DIM_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Requester bus plus the pixel-write port toward vga_adapter.
interface vga_write_arbiter_if
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]          req;
  logic [COORD_W*NUM_REQ-1:0]  req_x;
  logic [COORD_W*NUM_REQ-1:0]  req_y;
  logic [DIM_W*NUM_REQ-1:0]    req_w;
  logic [DIM_W*NUM_REQ-1:0]    req_h;
  logic [COLOUR_W*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]          req_erase;
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_REQ-1:0]          done;
  logic                        busy;
  logic [COORD_W-1:0]          vga_x;
  logic [COORD_W-1:0]          vga_y;
  logic [COLOUR_W-1:0]         vga_colour;
  logic                        vga_plot;

  // Sprite drawers drive requests and observe grants and pixels.
  modport master (
    output req, req_x, req_y, req_w, req_h, req_colour, req_erase,
    input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  // The arbiter consumes requests and owns the pixel port.
  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_colour, req_erase,
    output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/vga_write_arbiter_sprite_rasterizer.sv
// Walks a latched rectangle in row-major order, one registered pixel per clock,
// suppressing the plot strobe for pixels that fall off the screen.
module sprite_rasterizer
  import vga_pkg::*;
#(
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                active,
  input  logic [COORD_W-1:0]  rect_x,
  input  logic [COORD_W-1:0]  rect_y,
  input  logic [DIM_W-1:0]    rect_w,
  input  logic [DIM_W-1:0]    rect_h,
  input  logic [COLOUR_W-1:0] rect_colour,
  output logic [COORD_W-1:0]  pix_x,
  output logic [COORD_W-1:0]  pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                pix_plot,
  output logic                last
);

  logic [DIM_W-1:0]   cx;
  logic [DIM_W-1:0]   cy;
  logic [COORD_W:0]   sum_x;
  logic [COORD_W:0]   sum_y;

  // Ninth bit keeps the carry so coordinates past 255 are still clipped.
  assign sum_x = {1'b0, rect_x} + (COORD_W+1)'(cx);
  assign sum_y = {1'b0, rect_y} + (COORD_W+1)'(cy);
  assign last  = active && (cx == rect_w) && (cy == rect_h);

  // Pixel register and raster counters; plot is low whenever not drawing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx         <= '0;
      cy         <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
      pix_plot   <= 1'b0;
    end else if (start) begin
      cx       <= '0;
      cy       <= '0;
      pix_plot <= 1'b0;
    end else if (active) begin
      pix_x      <= sum_x[COORD_W-1:0];
      pix_y      <= sum_y[COORD_W-1:0];
      pix_colour <= rect_colour;
      pix_plot   <= (sum_x < (COORD_W+1)'(X_MAX)) && (sum_y < (COORD_W+1)'(Y_MAX));
      if (cx == rect_w) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end else begin
      pix_plot <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the vga_adapter write port among sprite drawers.
//
//  state | meaning
//  IDLE  | waiting for any request; picks winner from pointer upward
//  DRAW  | rasterizer emitting the latched rectangle, one pixel per clock
//  DONE  | pulse done for the winner, advance pointer, drop grant
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int                  NUM_REQ   = 4,
  parameter int                  X_MAX     = SCREEN_W,
  parameter int                  Y_MAX     = SCREEN_H,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  vga_write_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     win_reg;
  logic                 win_found;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 busy_q;
  logic [COORD_W-1:0]   lat_x;
  logic [COORD_W-1:0]   lat_y;
  logic [DIM_W-1:0]     lat_w;
  logic [DIM_W-1:0]     lat_h;
  logic [COLOUR_W-1:0]  lat_colour;
  logic                 start;
  logic                 last;

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req[(int'(ptr) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  assign start = (state == ST_IDLE) && win_found;

  // Arbitration state machine with registered grant/done/busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      win_reg    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_w      <= '0;
      lat_h      <= '0;
      lat_colour <= '0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            win_reg    <= win_idx;
            grant_q    <= NUM_REQ'(1) << win_idx;
            busy_q     <= 1'b1;
            lat_x      <= bus.req_x[COORD_W*int'(win_idx) +: COORD_W];
            lat_y      <= bus.req_y[COORD_W*int'(win_idx) +: COORD_W];
            lat_w      <= bus.req_w[DIM_W*int'(win_idx) +: DIM_W];
            lat_h      <= bus.req_h[DIM_W*int'(win_idx) +: DIM_W];
            lat_colour <= bus.req_erase[win_idx] ? BG_COLOUR
                        : bus.req_colour[COLOUR_W*int'(win_idx) +: COLOUR_W];
            state      <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (last) state <= ST_DONE;
        end
        ST_DONE: begin
          grant_q <= '0;
          done_q  <= NUM_REQ'(1) << win_reg;
          busy_q  <= 1'b0;
          ptr     <= (win_reg == IDX_W'(NUM_REQ-1)) ? '0 : win_reg + 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  sprite_rasterizer #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_raster (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .active      (state == ST_DRAW),
    .rect_x      (lat_x),
    .rect_y      (lat_y),
    .rect_w      (lat_w),
    .rect_h      (lat_h),
    .rect_colour (lat_colour),
    .pix_x       (bus.vga_x),
    .pix_y       (bus.vga_y),
    .pix_colour  (bus.vga_colour),
    .pix_plot    (bus.vga_plot),
    .last        (last)
  );

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: reset, raster order, clipping,
// round-robin rotation, erase colour and mid-draw reset abort.
module tb_vga_write_arbiter;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  vga_write_arbiter_if #(.NUM_REQ(4)) bus ();

  vga_write_arbiter #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input int i, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] w, input logic [3:0] h,
                          input logic [2:0] col, input logic er);
    bus.req_x[8*i +: 8]      = x;
    bus.req_y[8*i +: 8]      = y;
    bus.req_w[4*i +: 4]      = w;
    bus.req_h[4*i +: 4]      = h;
    bus.req_colour[3*i +: 3] = col;
    bus.req_erase[i]         = er;
  endtask

  // Advance one clock and check the registered pixel.
  task automatic pix(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                     input logic [2:0] ec, input logic ep);
    @(negedge clk);
    chk({tag, "_x"}, bus.vga_x, ex);
    chk({tag, "_y"}, bus.vga_y, ey);
    chk({tag, "_col"}, bus.vga_colour, ec);
    chk({tag, "_plot"}, bus.vga_plot, ep);
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    while (bus.grant == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.grant, exp);
  endtask

  // Counts clocks until done; exp_n is clocks from the current sample point.
  task automatic wait_done(input string tag, input logic [3:0] exp, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done == 4'b0 && n < 300);
    chk({tag, "_done"}, bus.done, exp);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_gnt0"}, bus.grant, 4'b0);
    chk({tag, "_plot0"}, bus.vga_plot, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.req = 4'b0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_w = '0;
    bus.req_h = '0;
    bus.req_colour = '0;
    bus.req_erase = '0;

    // Reset with all requests held
    set_rect(0, 8'd157, 8'd110, 4'd1, 4'd1, 3'b010, 1'b0);
    bus.req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.grant, 4'b0);
    chk("rst_done", bus.done, 4'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_plot", bus.vga_plot, 1'b0);
    chk("rst_x", bus.vga_x, 8'd0);
    chk("rst_y", bus.vga_y, 8'd0);
    chk("rst_col", bus.vga_colour, 3'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_grant", bus.grant, 4'b0001);
    chk("first_busy", bus.busy, 1'b1);
    bus.req = 4'b0001;

    // 2x2 near right/bottom edge, all on screen
    pix("r0p0", 8'd157, 8'd110, 3'b010, 1'b1);
    pix("r0p1", 8'd158, 8'd110, 3'b010, 1'b1);
    pix("r0p2", 8'd157, 8'd111, 3'b010, 1'b1);
    pix("r0p3", 8'd158, 8'd111, 3'b010, 1'b1);
    @(negedge clk);
    chk("r0_done", bus.done, 4'b0001);
    chk("r0_gnt", bus.grant, 4'b0);
    chk("r0_busy", bus.busy, 1'b0);
    chk("r0_plot", bus.vga_plot, 1'b0);
    bus.req = 4'b0;
    @(negedge clk);
    chk("done_clr", bus.done, 4'b0);
    chk("hold_x", bus.vga_x, 8'd158);
    chk("hold_y", bus.vga_y, 8'd111);
    chk("idle_busy", bus.busy, 1'b0);

    // Round robin: pointer now 1, so 2 is served before 0
    set_rect(0, 8'd10, 8'd10, 4'd0, 4'd0, 3'b100, 1'b0);
    set_rect(2, 8'd20, 8'd20, 4'd0, 4'd0, 3'b110, 1'b0);
    set_rect(3, 8'd30, 8'd30, 4'd0, 4'd0, 3'b111, 1'b0);
    bus.req = 4'b0101;
    wait_grant("rr_a_g2", 4'b0100);
    wait_done("rr_a_d2", 4'b0100, 2);
    bus.req[2] = 1'b0;
    wait_grant("rr_a_g0", 4'b0001);
    wait_done("rr_a_d0", 4'b0001, 2);
    bus.req[0] = 1'b0;
    // Pointer back at 1: order 2, 3, then wrap to 0
    bus.req = 4'b1101;
    wait_grant("rr_b_g2", 4'b0100);
    wait_done("rr_b_d2", 4'b0100, 2);
    bus.req[2] = 1'b0;
    wait_grant("rr_b_g3", 4'b1000);
    chk("rr_b_x3", bus.vga_x, 8'd20);
    wait_done("rr_b_d3", 4'b1000, 2);
    bus.req[3] = 1'b0;
    wait_grant("rr_b_g0", 4'b0001);
    wait_done("rr_b_d0", 4'b0001, 2);
    bus.req[0] = 1'b0;

    // Corner clipping: only (159,119) is on screen
    set_rect(1, 8'd159, 8'd119, 4'd1, 4'd1, 3'b111, 1'b0);
    bus.req = 4'b0010;
    wait_grant("clip_g1", 4'b0010);
    pix("clip0", 8'd159, 8'd119, 3'b111, 1'b1);
    pix("clip1", 8'd160, 8'd119, 3'b111, 1'b0);
    pix("clip2", 8'd159, 8'd120, 3'b111, 1'b0);
    pix("clip3", 8'd160, 8'd120, 3'b111, 1'b0);
    wait_done("clip", 4'b0010, 1);
    bus.req = 4'b0;

    // Erase draws background; req dropped and inputs changed mid-draw
    set_rect(3, 8'd10, 8'd20, 4'd2, 4'd0, 3'b001, 1'b1);
    bus.req = 4'b1000;
    wait_grant("er_g3", 4'b1000);
    bus.req = 4'b0;
    set_rect(3, 8'd99, 8'd99, 4'd9, 4'd9, 3'b101, 1'b0);
    pix("er0", 8'd10, 8'd20, 3'b000, 1'b1);
    pix("er1", 8'd11, 8'd20, 3'b000, 1'b1);
    pix("er2", 8'd12, 8'd20, 3'b000, 1'b1);
    wait_done("er", 4'b1000, 1);

    // Reset on third pixel of a 4x4 draw aborts it
    set_rect(0, 8'd5, 8'd6, 4'd3, 4'd3, 3'b101, 1'b0);
    bus.req = 4'b0001;
    wait_grant("ab_g0", 4'b0001);
    pix("ab0", 8'd5, 8'd6, 3'b101, 1'b1);
    pix("ab1", 8'd6, 8'd6, 3'b101, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ab_plot", bus.vga_plot, 1'b0);
    chk("ab_grant", bus.grant, 4'b0);
    chk("ab_busy", bus.busy, 1'b0);
    chk("ab_x", bus.vga_x, 8'd0);
    chk("ab_done", bus.done, 4'b0);
    bus.req = 4'b0;
    repeat (3) @(negedge clk);
    chk("ab_done_hold", bus.done, 4'b0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("ab_no_done", bus.done, 4'b0);
    chk("ab_idle", bus.busy, 1'b0);

    // Recovery after abort: pointer reset to 0, single-pixel draw works
    set_rect(2, 8'd1, 8'd2, 4'd0, 4'd0, 3'b011, 1'b0);
    bus.req = 4'b0100;
    wait_grant("rec_g2", 4'b0100);
    pix("rec0", 8'd1, 8'd2, 3'b011, 1'b1);
    wait_done("rec", 4'b0100, 1);
    bus.req = 4'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
